// File: rtl/mips_defs_pkg.sv
// Shared MIPS32 front-end definitions: widths, NOP encoding, fetch state and byte swap.
package mips_defs;

  localparam int unsigned PC_W   = 32;
  localparam int unsigned INST_W = 32;

  localparam logic [INST_W-1:0] NOP = 32'h0000_0000;

  typedef enum logic {
    RUN   = 1'b0,
    FAULT = 1'b1
  } fetch_state_e;

  // ROM stores words byte-reversed relative to MIPS instruction order.
  function automatic logic [INST_W-1:0] bswap(input logic [INST_W-1:0] d);
    return {d[7:0], d[15:8], d[23:16], d[31:24]};
  endfunction

endpackage

// File: rtl/fetch_skid_buf.sv
// Two-entry FIFO of {pc, inst} between fetch and decode; head is read straight from storage.
module fetch_skid_buf
  import mips_defs::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              push_i,
  input  logic              pop_i,
  input  logic              flush_i,
  input  logic [PC_W-1:0]   push_pc_i,
  input  logic [INST_W-1:0] push_inst_i,
  output logic [PC_W-1:0]   head_pc_o,
  output logic [INST_W-1:0] head_inst_o,
  output logic              valid_o,
  output logic [1:0]        count_o
);

  logic [PC_W-1:0]   pc_q   [2];
  logic [INST_W-1:0] inst_q [2];
  logic              rd_ptr_q, rd_ptr_d;
  logic              wr_ptr_q, wr_ptr_d;
  logic [1:0]        count_q, count_d;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      rd_ptr_d = 1'b0;
      wr_ptr_d = 1'b0;
      count_d  = 2'd0;
    end else begin
      if (push_i) wr_ptr_d = ~wr_ptr_q;
      if (pop_i)  rd_ptr_d = ~rd_ptr_q;
      unique case ({push_i, pop_i})
        2'b10:   count_d = count_q + 2'd1;
        2'b01:   count_d = count_q - 2'd1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= 2'd0;
      for (int i = 0; i < 2; i++) begin
        pc_q[i]   <= '0;
        inst_q[i] <= '0;
      end
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      if (push_i && !flush_i) begin
        pc_q[wr_ptr_q]   <= push_pc_i;
        inst_q[wr_ptr_q] <= push_inst_i;
      end
    end
  end

  assign head_pc_o   = pc_q[rd_ptr_q];
  assign head_inst_o = inst_q[rd_ptr_q];
  assign valid_o     = (count_q != 2'd0);
  assign count_o     = count_q;

endmodule

// File: rtl/inst_fetch_unit.sv
// MIPS32 instruction fetch: PC sequencing, ROM byte swap, redirect and misalignment fault.
module inst_fetch_unit
  import mips_defs::*;
#(
  parameter int unsigned     ADDR_W    = 5,
  parameter int unsigned     ROM_DEPTH = 28,
  parameter logic [PC_W-1:0] RESET_PC  = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [INST_W-1:0] rom_data,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [INST_W-1:0] inst_o,
  output logic [PC_W-1:0]   inst_pc,
  input  logic              redirect_valid,
  input  logic [PC_W-1:0]   redirect_pc,
  output logic              fault,
  output logic [PC_W-1:0]   fault_pc
);

  fetch_state_e      state_q, state_d;
  logic [PC_W-1:0]   fetch_pc_q, fetch_pc_d;
  logic              fault_q, fault_d;
  logic [PC_W-1:0]   fault_pc_q, fault_pc_d;

  logic              pop, push, flush, misaligned, in_range;
  logic [1:0]        count;
  logic [INST_W-1:0] fetch_inst;
  logic [PC_W-3:0]   word_idx;

  assign word_idx   = fetch_pc_q[PC_W-1:2];
  assign in_range   = (word_idx < (PC_W-2)'(ROM_DEPTH));
  assign fetch_inst = in_range ? bswap(rom_data) : NOP;
  assign rom_addr   = fetch_pc_q[ADDR_W+1:2];
  assign misaligned = (redirect_pc[1:0] != 2'b00);

  // A slot is free if the buffer is not full, or the head leaves this cycle.
  always_comb begin
    pop   = inst_valid && inst_ready;
    flush = (state_q == RUN) && redirect_valid;
    push  = (state_q == RUN) && !redirect_valid && ((count != 2'd2) || pop);
  end

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    fault_d    = fault_q;
    fault_pc_d = fault_pc_q;
    if (flush) begin
      if (misaligned) begin
        state_d    = FAULT;
        fault_d    = 1'b1;
        fault_pc_d = redirect_pc;
      end else begin
        fetch_pc_d = redirect_pc;
      end
    end else if (push) begin
      fetch_pc_d = fetch_pc_q + 32'd4;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= RUN;
      fetch_pc_q <= RESET_PC;
      fault_q    <= 1'b0;
      fault_pc_q <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      fault_q    <= fault_d;
      fault_pc_q <= fault_pc_d;
    end
  end

  fetch_skid_buf u_buf (
    .clk         (clk),
    .rst         (rst),
    .push_i      (push),
    .pop_i       (pop),
    .flush_i     (flush),
    .push_pc_i   (fetch_pc_q),
    .push_inst_i (fetch_inst),
    .head_pc_o   (inst_pc),
    .head_inst_o (inst_o),
    .valid_o     (inst_valid),
    .count_o     (count)
  );

  assign fault    = fault_q;
  assign fault_pc = fault_pc_q;

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Bench for inst_fetch_unit: directed vector table plus a random-ready in-order scoreboard.
module tb_inst_fetch_unit;

  logic        clk = 1'b0;
  logic        rst, inst_ready, redirect_valid;
  logic [31:0] redirect_pc, rom_data, inst_o, inst_pc, fault_pc;
  logic [4:0]  rom_addr;
  logic        inst_valid, fault;

  logic [31:0] rom_mem [32];
  int tests = 0;
  int failed = 0;

  always #5 clk = ~clk;

  assign rom_data = rom_mem[rom_addr];

  inst_fetch_unit #(
    .ADDR_W    (5),
    .ROM_DEPTH (28),
    .RESET_PC  (32'h0000_0000)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .rom_addr       (rom_addr),
    .rom_data       (rom_data),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst_o         (inst_o),
    .inst_pc        (inst_pc),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .fault          (fault),
    .fault_pc       (fault_pc)
  );

  typedef struct packed {
    logic        rst;
    logic        ready;
    logic        rv;
    logic [31:0] rpc;
    logic        ev;
    logic [31:0] epc;
    logic [31:0] einst;
    logic [4:0]  eaddr;
    logic        efault;
    logic [31:0] efpc;
  } vec_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];

  function automatic logic [31:0] swap32(input logic [31:0] d);
    return {d[7:0], d[15:8], d[23:16], d[31:24]};
  endfunction

  function automatic logic [31:0] exp_inst(input logic [31:0] pc);
    logic [29:0] idx;
    idx = pc[31:2];
    return (idx < 30'd28) ? swap32(rom_mem[idx[4:0]]) : 32'h0;
  endfunction

  function automatic vec_t mk(input logic r, input logic rdy, input logic rv,
                              input logic [31:0] rpc, input logic ev, input logic [31:0] epc,
                              input logic [31:0] einst, input logic [4:0] eaddr,
                              input logic ef, input logic [31:0] efpc);
    vec_t v;
    v = '{rst: r, ready: rdy, rv: rv, rpc: rpc, ev: ev, epc: epc, einst: einst,
          eaddr: eaddr, efault: ef, efpc: efpc};
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 32; i++)
      rom_mem[i] = (i < 28) ? {8'(i), 8'h5a, 8'(i + 3), 8'hc3} : 32'hdead_beef;
    rom_mem[0]  = 32'hff00_0134;
    rom_mem[1]  = 32'h0000_0000;
    rom_mem[3]  = 32'h0300_01a0;
    rom_mem[16] = 32'h0300_0280;

    rst = 1'b1; inst_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;

    // Ready held high: one instruction per cycle from reset.
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 1, 32'h0, 32'h340100ff, 1, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 1, 32'h4, 32'h0, 2, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 1, 32'h8, swap32(rom_mem[2]), 3, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 1, 32'hc, 32'ha0010003, 4, 0, 0));
    // Ready low: buffer fills to 2, fetch_pc holds at 0x8.
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 32'h0, 32'h340100ff, 1, 0, 0));
    for (int i = 0; i < 4; i++)
      vecs.push_back(mk(0, 0, 0, 0, 1, 32'h0, 32'h340100ff, 2, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 1, 32'h4, 32'h0, 3, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 1, 32'h8, swap32(rom_mem[2]), 4, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 1, 32'hc, 32'ha0010003, 5, 0, 0));
    // Redirect to 0x40 with two entries buffered.
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 32'h0, 32'h340100ff, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 32'h0, 32'h340100ff, 2, 0, 0));
    vecs.push_back(mk(0, 0, 1, 32'h40, 0, 0, 0, 16, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 1, 32'h40, 32'h80020003, 17, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 1, 32'h44, swap32(rom_mem[17]), 18, 0, 0));
    // Misaligned redirect faults; later redirects are ignored until reset.
    vecs.push_back(mk(0, 0, 1, 32'h42, 0, 0, 0, 18, 1, 32'h42));
    vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0, 18, 1, 32'h42));
    vecs.push_back(mk(0, 1, 1, 32'h0, 0, 0, 0, 18, 1, 32'h42));
    vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0, 18, 1, 32'h42));
    vecs.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 1, 32'h0, 32'h340100ff, 1, 0, 0));
    // Full buffer with ready toggling, then reset mid-stream.
    vecs.push_back(mk(0, 0, 0, 0, 1, 32'h0, 32'h340100ff, 2, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 1, 32'h4, 32'h0, 3, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 32'h4, 32'h0, 3, 0, 0));
    vecs.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 1, 32'h0, 32'h340100ff, 1, 0, 0));

    for (int i = 0; i < vecs.size(); i++) begin
      rst            = vecs[i].rst;
      inst_ready     = vecs[i].ready;
      redirect_valid = vecs[i].rv;
      redirect_pc    = vecs[i].rpc;
      step();
      check($sformatf("v%0d.valid", i), 32'(inst_valid), 32'(vecs[i].ev));
      check($sformatf("v%0d.rom_addr", i), 32'(rom_addr), 32'(vecs[i].eaddr));
      check($sformatf("v%0d.fault", i), 32'(fault), 32'(vecs[i].efault));
      check($sformatf("v%0d.fault_pc", i), fault_pc, vecs[i].efpc);
      if (vecs[i].ev || vecs[i].rst) begin
        check($sformatf("v%0d.inst_pc", i), inst_pc, vecs[i].epc);
        check($sformatf("v%0d.inst", i), inst_o, vecs[i].einst);
      end
    end

    // Random ready: sequential stream past the populated ROM, in order, no gaps.
    rst = 1'b1; inst_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    step();
    rst = 1'b0;
    for (int i = 0; i < 40; i++)
      sb.push_back('{pc: 32'(i * 4), inst: exp_inst(32'(i * 4))});
    for (int cyc = 0; cyc < 400 && sb.size() > 0; cyc++) begin
      inst_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (inst_valid && inst_ready) begin
        check("sb.inst_pc", inst_pc, sb[0].pc);
        check("sb.inst", inst_o, sb[0].inst);
        void'(sb.pop_front());
      end
      step();
    end
    if (sb.size() != 0) begin
      tests++;
      failed++;
      $display("FAIL sb.timeout: %0d entries outstanding, expected 0", sb.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
